// File: rtl/excp_pkg.sv
// Purpose : shared types and constants for exception/ERTN commit sequencing.
// Latency : n/a (package).
// Backpressure : n/a (package).
package excp_pkg;

  // Cause vector layout {ALE,BRK,SYS,IPE,INE,ADEF}
  localparam int CAUSE_W    = 6;
  localparam int CAUSE_ADEF = 0;
  localparam int CAUSE_INE  = 1;
  localparam int CAUSE_IPE  = 2;
  localparam int CAUSE_SYS  = 3;
  localparam int CAUSE_BRK  = 4;
  localparam int CAUSE_ALE  = 5;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;
  localparam logic [5:0] ECODE_IPE  = 6'h0E;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2,
    HOLD  = 2'd3
  } excp_state_t;

  typedef enum logic {
    KIND_EXCP = 1'b0,
    KIND_ERTN = 1'b1
  } flush_kind_t;

endpackage

// File: rtl/excp_prio_enc.sv
// Purpose : picks the highest-priority cause (INT > ADEF > INE > IPE > SYS > BRK > ALE).
// Latency : combinational.
// Backpressure : none.
// Ports   : has_int (already masked by caller), cause vector in; hit + ecode out.
module excp_prio_enc
  import excp_pkg::*;
(
  input  logic               has_int,
  input  logic [CAUSE_W-1:0] cause,
  output logic               hit,
  output logic [5:0]         ecode
);

  always_comb begin
    hit   = has_int | (|cause);
    ecode = ECODE_INT;
    if (has_int)                ecode = ECODE_INT;
    else if (cause[CAUSE_ADEF]) ecode = ECODE_ADEF;
    else if (cause[CAUSE_INE])  ecode = ECODE_INE;
    else if (cause[CAUSE_IPE])  ecode = ECODE_IPE;
    else if (cause[CAUSE_SYS])  ecode = ECODE_SYS;
    else if (cause[CAUSE_BRK])  ecode = ECODE_BRK;
    else if (cause[CAUSE_ALE])  ecode = ECODE_ALE;
  end

endmodule

// File: rtl/excp_commit_ctrl.sv
// Purpose : sequences exception/interrupt/ERTN commit: CSR strobe, pipe flush, fetch redirect.
// Latency : strobe one cycle after the commit, redirect_valid from the cycle after that.
// Backpressure : commit_ready low in FLUSH/REDIR; redirect held until redirect_ready.
// Ports   : commit_* from writeback, has_int/csr_eentry/csr_era from CSR file,
//           excp_flush/ertn_flush/era_in/ecode_out/esubcode_out to CSR file,
//           redirect_valid/ready/pc to fetch, retire_en and pipe_flush to the pipeline.
module excp_commit_ctrl
  import excp_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit_valid,
  output logic               commit_ready,
  input  logic [PC_W-1:0]    commit_pc,
  input  logic [CAUSE_W-1:0] commit_excp,
  input  logic               commit_ertn,
  input  logic               has_int,
  input  logic [PC_W-1:0]    csr_eentry,
  input  logic [PC_W-1:0]    csr_era,
  output logic               retire_en,
  output logic               excp_flush,
  output logic               ertn_flush,
  output logic [PC_W-1:0]    era_in,
  output logic [5:0]         ecode_out,
  output logic [8:0]         esubcode_out,
  output logic               pipe_flush,
  output logic               redirect_valid,
  input  logic               redirect_ready,
  output logic [PC_W-1:0]    redirect_pc
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF_CYC);

  excp_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  flush_kind_t kind_q;
  logic [5:0]  ecode_q;
  logic [PC_W-1:0] era_q, target_q;

  logic fire, int_ok, take_excp, take_ertn, capture;
  logic enc_hit;
  logic [5:0] enc_ecode;

  assign commit_ready = (state_q == IDLE) || (state_q == HOLD);
  assign fire         = commit_valid & commit_ready;
  // Interrupts only get through in IDLE with the holdoff counter drained.
  assign int_ok       = has_int & (state_q == IDLE) & (cnt_q == 4'd0);

  excp_prio_enc u_prio_enc (
    .has_int (int_ok),
    .cause   (commit_excp),
    .hit     (enc_hit),
    .ecode   (enc_ecode)
  );

  assign take_excp = fire & enc_hit;
  assign take_ertn = fire & commit_ertn & ~take_excp;
  assign retire_en = fire & ~take_excp & ~take_ertn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_excp | take_ertn) begin
          state_d = FLUSH;
          capture = 1'b1;
        end
      end
      FLUSH: state_d = REDIR;
      REDIR: begin
        if (redirect_ready) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (take_excp | take_ertn) begin
          state_d = FLUSH;
          cnt_d   = 4'd0;
          capture = 1'b1;
        end else if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      kind_q   <= KIND_EXCP;
      ecode_q  <= 6'd0;
      era_q    <= '0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        kind_q   <= take_excp ? KIND_EXCP : KIND_ERTN;
        ecode_q  <= enc_ecode;
        era_q    <= commit_pc;
        target_q <= take_excp ? csr_eentry : csr_era;
      end
    end
  end

  assign excp_flush     = (state_q == FLUSH) & (kind_q == KIND_EXCP);
  assign ertn_flush     = (state_q == FLUSH) & (kind_q == KIND_ERTN);
  assign pipe_flush     = (state_q == FLUSH) || (state_q == REDIR);
  assign redirect_valid = (state_q == REDIR);
  assign redirect_pc    = target_q;
  assign ecode_out      = ecode_q;
  assign era_in         = era_q;
  assign esubcode_out   = 9'd0;

endmodule

// File: tb/tb_excp_commit_ctrl.sv
// Purpose : directed self-checking bench for excp_commit_ctrl.
// Latency : n/a.
// Backpressure : exercises redirect_ready stalls.
module tb_excp_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        commit_valid, commit_ready;
  logic [31:0] commit_pc;
  logic [5:0]  commit_excp;
  logic        commit_ertn, has_int;
  logic [31:0] csr_eentry, csr_era;
  logic        retire_en, excp_flush, ertn_flush;
  logic [31:0] era_in;
  logic [5:0]  ecode_out;
  logic [8:0]  esubcode_out;
  logic        pipe_flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  int n_checks = 0;
  int n_fail   = 0;

  excp_commit_ctrl #(.PC_W(32), .HOLDOFF_CYC(2)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_excp(commit_excp), .commit_ertn(commit_ertn),
    .has_int(has_int), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .retire_en(retire_en), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .era_in(era_in), .ecode_out(ecode_out), .esubcode_out(esubcode_out),
    .pipe_flush(pipe_flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_commit();
    commit_valid = 1'b0;
    commit_excp  = 6'd0;
    commit_ertn  = 1'b0;
    has_int      = 1'b0;
  endtask

  // Presents one excepting/ERTN commit in an IDLE cycle and leaves the bench in the FLUSH cycle.
  task automatic commit_flush(input logic [31:0] pc, input logic [5:0] excp,
                              input logic ertn, input logic hint);
    commit_valid = 1'b1;
    commit_pc    = pc;
    commit_excp  = excp;
    commit_ertn  = ertn;
    has_int      = hint;
    settle();
    check_eq("commit_no_retire", 32'(retire_en), 0);
    check_eq("commit_ready_idle", 32'(commit_ready), 1);
    step();
    clear_commit();
    settle();
  endtask

  // From the FLUSH cycle, with redirect_ready=1: REDIR, HOLD, HOLD, then IDLE.
  task automatic flush_to_idle();
    step();
    step();
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_commit();
    commit_pc      = 32'd0;
    csr_eentry     = 32'd0;
    csr_era        = 32'd0;
    redirect_ready = 1'b0;
    step();
    step();
    settle();
    check_eq("rst_commit_ready", 32'(commit_ready), 1);
    check_eq("rst_excp_flush", 32'(excp_flush), 0);
    check_eq("rst_pipe_flush", 32'(pipe_flush), 0);
    check_eq("rst_redirect_valid", 32'(redirect_valid), 0);
    check_eq("rst_ecode", 32'(ecode_out), 0);
    check_eq("rst_era_in", era_in, 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
    reset = 1'b0;
    step();

    // SYS exception
    csr_eentry     = 32'h1C008000;
    csr_era        = 32'h1C000200;
    redirect_ready = 1'b1;
    commit_flush(32'h1C000100, 6'b001000, 1'b0, 1'b0);
    check_eq("sys_excp_flush", 32'(excp_flush), 1);
    check_eq("sys_ertn_flush", 32'(ertn_flush), 0);
    check_eq("sys_ecode", 32'(ecode_out), 32'h0B);
    check_eq("sys_era_in", era_in, 32'h1C000100);
    check_eq("sys_pipe_flush", 32'(pipe_flush), 1);
    check_eq("sys_flush_ready", 32'(commit_ready), 0);
    check_eq("sys_flush_rv", 32'(redirect_valid), 0);
    check_eq("sys_esubcode", 32'(esubcode_out), 0);
    step();
    check_eq("sys_redir_valid", 32'(redirect_valid), 1);
    check_eq("sys_redir_pc", redirect_pc, 32'h1C008000);
    check_eq("sys_redir_strobe", 32'(excp_flush), 0);
    check_eq("sys_redir_pipe", 32'(pipe_flush), 1);
    step();
    check_eq("sys_hold_ready", 32'(commit_ready), 1);
    check_eq("sys_hold_rv", 32'(redirect_valid), 0);
    check_eq("sys_hold_pipe", 32'(pipe_flush), 0);
    check_eq("sys_hold_ecode", 32'(ecode_out), 32'h0B);
    step();
    step();

    // ALE+INE with interrupt, then without
    commit_flush(32'h1C000110, 6'b100010, 1'b0, 1'b1);
    check_eq("int_beats_excp_flush", 32'(excp_flush), 1);
    check_eq("int_beats_excp_ecode", 32'(ecode_out), 32'h00);
    flush_to_idle();
    commit_flush(32'h1C000114, 6'b100010, 1'b0, 1'b0);
    check_eq("ine_beats_ale_ecode", 32'(ecode_out), 32'h0D);
    check_eq("ine_era_in", era_in, 32'h1C000114);
    flush_to_idle();

    // ERTN, then ERTN with ADEF
    commit_flush(32'h1C000120, 6'b000000, 1'b1, 1'b0);
    check_eq("ertn_ertn_flush", 32'(ertn_flush), 1);
    check_eq("ertn_excp_flush", 32'(excp_flush), 0);
    check_eq("ertn_pipe_flush", 32'(pipe_flush), 1);
    step();
    check_eq("ertn_redir_pc", redirect_pc, 32'h1C000200);
    step();
    step();
    step();
    commit_flush(32'h1C000130, 6'b000001, 1'b1, 1'b0);
    check_eq("ertn_adef_excp_flush", 32'(excp_flush), 1);
    check_eq("ertn_adef_ertn_flush", 32'(ertn_flush), 0);
    check_eq("ertn_adef_ecode", 32'(ecode_out), 32'h08);
    step();
    check_eq("ertn_adef_redir_pc", redirect_pc, 32'h1C008000);
    step();
    step();
    step();

    // BRK with redirect stall; ready=1 during FLUSH must be ignored
    csr_eentry = 32'h1C009000;
    commit_flush(32'h1C000300, 6'b010000, 1'b0, 1'b0);
    check_eq("brk_ecode", 32'(ecode_out), 32'h0C);
    step();
    redirect_ready = 1'b0;
    commit_valid   = 1'b1;
    commit_pc      = 32'h1C000310;
    for (int i = 0; i < 5; i++) begin
      settle();
      check_eq("stall_rv", 32'(redirect_valid), 1);
      check_eq("stall_rpc", redirect_pc, 32'h1C009000);
      check_eq("stall_commit_ready", 32'(commit_ready), 0);
      check_eq("stall_retire", 32'(retire_en), 0);
      step();
    end
    redirect_ready = 1'b1;
    settle();
    check_eq("stall_release_rv", 32'(redirect_valid), 1);
    step();

    // HOLD: interrupts masked, normal commits retire; interrupt taken on first IDLE commit
    has_int      = 1'b1;
    commit_valid = 1'b1;
    commit_pc    = 32'h1C000400;
    commit_excp  = 6'd0;
    settle();
    check_eq("hold1_retire", 32'(retire_en), 1);
    check_eq("hold1_ready", 32'(commit_ready), 1);
    step();
    check_eq("hold2_retire", 32'(retire_en), 1);
    check_eq("hold2_excp_flush", 32'(excp_flush), 0);
    step();
    check_eq("idle_int_retire", 32'(retire_en), 0);
    check_eq("idle_int_ready", 32'(commit_ready), 1);
    step();
    clear_commit();
    settle();
    check_eq("int_excp_flush", 32'(excp_flush), 1);
    check_eq("int_ecode", 32'(ecode_out), 32'h00);
    check_eq("int_era_in", era_in, 32'h1C000400);
    flush_to_idle();

    // Reset during REDIR
    commit_flush(32'h1C000500, 6'b000100, 1'b0, 1'b0);
    check_eq("ipe_ecode", 32'(ecode_out), 32'h0E);
    redirect_ready = 1'b0;
    step();
    check_eq("rstmid_redir_rv", 32'(redirect_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    settle();
    check_eq("rstmid_rv", 32'(redirect_valid), 0);
    check_eq("rstmid_ready", 32'(commit_ready), 1);
    check_eq("rstmid_pipe", 32'(pipe_flush), 0);
    check_eq("rstmid_excp_flush", 32'(excp_flush), 0);
    check_eq("rstmid_ecode", 32'(ecode_out), 0);
    step();
    check_eq("rstmid_next_excp_flush", 32'(excp_flush), 0);
    check_eq("rstmid_next_ertn_flush", 32'(ertn_flush), 0);
    check_eq("rstmid_next_rv", 32'(redirect_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
